mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; rst_n input 1, reset, asynchronous, active-low.
REQ-002 SHALL have: halt input 1, CPU halt, freezes all state; ex_valid input 1, instruction present from execute stage.
REQ-003 SHALL have: ex_alu_result input 32, registered ALU result, used as the address or passthrough data; ex_store_data input 32, rs2 value.
REQ-004 SHALL have: ex_mem_op input 4, encoded as 0000 none, 0001 LB, 0010 LH, 0011 LW, 0100 LBU, 0101 LHU, 1001 SB, 1010 SH, 1011 SW; other codes are reserved.
REQ-005 SHALL have: ex_rd input 5, destination register; ex_reg_write input 1, writeback enable.
REQ-006 SHALL have: dmem_req output 1; dmem_we output 1; dmem_addr output 32, word-aligned; dmem_wdata output 32; dmem_wstrb output 4.
REQ-007 SHALL have: dmem_ack input 1, one-cycle completion; dmem_rdata input 32, valid when dmem_ack is high.
REQ-008 SHALL have: mem_stall output 1, upstream hold; wb_valid output 1; wb_rd output 5; wb_data output 32; wb_reg_write output 1; misalign_exc output 1.

Function
REQ-009 SHALL implement FSM states IDLE and REQ; mem_stall SHALL equal (state==REQ), derived combinationally from the state register.
REQ-010 In IDLE with ex_valid=1 and halt=0, the block SHALL accept the instruction and register address, store data, op, rd and reg_write.
REQ-011 Op none or reserved: next cycle wb_valid=1, wb_data=ex_alu_result, wb_rd=ex_rd; wb_reg_write=ex_reg_write for none, and 0 for reserved; state stays IDLE; latency 1 cycle.
REQ-012 Aligned load/store: state goes to REQ; dmem_req SHALL be registered, asserted for the whole REQ state, and driven low in IDLE.
REQ-013 While in REQ, dmem_addr={addr[31:2],2'b00}; dmem_we=1 for stores and 0 for loads; all dmem outputs SHALL stay stable until ack.
REQ-014 On dmem_ack=1 in REQ: the block SHALL return to IDLE and, in the next cycle, pulse wb_valid=1 for one cycle with wb_rd = the registered rd.
REQ-015 Store strobes: SW wstrb=1111, wdata=store data; SH wstrb=0011<<(2*addr[1]), wdata={2{sd[15:0]}}; SB wstrb=0001<<addr[1:0], wdata={4{sd[7:0]}}.
REQ-016 Loads SHALL select byte lane rdata>>(8*addr[1:0]); LB/LH sign-extend, LBU/LHU zero-extend, LW pass all 32 bits; the extended value drives wb_data.
REQ-017 Stores SHALL produce wb_reg_write=0 and wb_data=0 on their wb_valid pulse; loads SHALL produce wb_reg_write = the registered reg_write.
REQ-018 Misaligned access: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL issue no dmem_req and stay in IDLE.
REQ-019 For a misaligned access, the next cycle SHALL have misalign_exc=1 for exactly one cycle and wb_valid=0.
REQ-020 wb_valid and misalign_exc SHALL be single-cycle pulses, and SHALL be 0 in any cycle without a completion or exception.
REQ-021 halt=1 SHALL freeze the FSM and all output registers at their current values; dmem_ack arriving during halt SHALL be ignored, and the memory SHALL hold ack until halt falls.
REQ-022 ex_valid=0 in IDLE SHALL produce wb_valid=0 in the next cycle; the registered fields MAY hold stale values.
REQ-023 dmem_ack while in IDLE SHALL be ignored.

Reset
REQ-024 On rst_n=0, asynchronously: state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_wstrb=0.
REQ-025 On rst_n=0, asynchronously: wb_valid=0, wb_rd=0, wb_data=0, wb_reg_write=0, misalign_exc=0, and mem_stall=0.
REQ-026 Reset during REQ SHALL abandon the transaction: dmem_req falls immediately and no wb_valid pulse follows.
REQ-027 The first instruction after reset release SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-028 Passthrough: op=0000, alu=0x0000_1234, rd=5, rw=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, wb_reg_write=1, and no dmem_req.
REQ-029 LB: addr=0x103, rdata=0x80FF_FF7F with ack 2 cycles after req -> dmem_addr=0x100, mem_stall high for 3 cycles, then wb_data=0xFFFF_FF80.
REQ-030 SH: addr=0x202, sd=0xAAAA_BEEF -> dmem_we=1, dmem_addr=0x200, wstrb=1100, wdata=0xBEEF_BEEF; after ack, wb_valid=1 and wb_reg_write=0.
REQ-031 LW with addr=0x301 -> no dmem_req, misalign_exc=1 for one cycle, wb_valid=0, and a following op accepted the next cycle.
REQ-032 LHU in REQ with halt=1 for 3 cycles then ack=1 with rdata=0x0000_8001 -> outputs frozen during halt; wb_data=0x0000_8001 after ack.
REQ-033 rst_n pulsed low in REQ -> dmem_req=0 immediately, all outputs at reset values, and no wb_valid afterwards.

Source files
------------

// File: rtl/mem_stage.sv
// Memory access stage: load/store issue to the data port, lane steering,
// sign/zero extension and misalignment detection with a 2-state handshake FSM.
module mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [3:0]  ex_mem_op,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_reg_write,
  output logic        misalign_exc
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_LB   = 4'b0001;
  localparam logic [3:0] OP_LH   = 4'b0010;
  localparam logic [3:0] OP_LW   = 4'b0011;
  localparam logic [3:0] OP_LBU  = 4'b0100;
  localparam logic [3:0] OP_LHU  = 4'b0101;
  localparam logic [3:0] OP_SB   = 4'b1001;
  localparam logic [3:0] OP_SH   = 4'b1010;
  localparam logic [3:0] OP_SW   = 4'b1011;

  logic [0:0]  state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic        rw_q, rw_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        wbv_q, wbv_d;
  logic [4:0]  wbrd_q, wbrd_d;
  logic [31:0] wbdata_q, wbdata_d;
  logic        wbrw_q, wbrw_d;
  logic        mis_q, mis_d;

  logic        in_load;
  logic        in_store;
  logic        in_mis;
  logic        q_store;
  logic [31:0] lane;
  logic [31:0] load_val;

  always_comb begin
    in_load  = 1'b0;
    in_store = 1'b0;
    unique case (ex_mem_op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: in_load = 1'b1;
      OP_SB, OP_SH, OP_SW: in_store = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    in_mis = 1'b0;
    unique case (ex_mem_op)
      OP_LH, OP_LHU, OP_SH: in_mis = ex_alu_result[0];
      OP_LW, OP_SW: in_mis = |ex_alu_result[1:0];
      default: ;
    endcase
  end

  assign q_store = op_q[3];
  assign lane = dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_val = lane;
    unique case (op_q)
      OP_LB:  load_val = {{24{lane[7]}}, lane[7:0]};
      OP_LH:  load_val = {{16{lane[15]}}, lane[15:0]};
      OP_LBU: load_val = {24'd0, lane[7:0]};
      OP_LHU: load_val = {16'd0, lane[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rw_d     = rw_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    wbv_d    = wbv_q;
    wbrd_d   = wbrd_q;
    wbdata_d = wbdata_q;
    wbrw_d   = wbrw_q;
    mis_d    = mis_q;
    // halt leaves every register untouched, pulses included
    if (!halt) begin
      wbv_d = 1'b0;
      mis_d = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          req_d = 1'b0;
          if (ex_valid) begin
            off_d = ex_alu_result[1:0];
            op_d  = ex_mem_op;
            rd_d  = ex_rd;
            rw_d  = ex_reg_write;
            if ((in_load || in_store) && in_mis) begin
              mis_d = 1'b1;
            end else if (in_load || in_store) begin
              state_d = S_REQ;
              req_d   = 1'b1;
              we_d    = in_store;
              addr_d  = {ex_alu_result[31:2], 2'b00};
              wdata_d = ex_store_data;
              wstrb_d = 4'b0000;
              unique case (ex_mem_op)
                OP_SW: wstrb_d = 4'b1111;
                OP_SH: begin
                  wstrb_d = 4'b0011 << {ex_alu_result[1], 1'b0};
                  wdata_d = {2{ex_store_data[15:0]}};
                end
                OP_SB: begin
                  wstrb_d = 4'b0001 << ex_alu_result[1:0];
                  wdata_d = {4{ex_store_data[7:0]}};
                end
                default: ;
              endcase
            end else begin
              wbv_d    = 1'b1;
              wbrd_d   = ex_rd;
              wbdata_d = ex_alu_result;
              wbrw_d   = (ex_mem_op == OP_NONE) && ex_reg_write;
            end
          end
        end
        S_REQ: begin
          if (dmem_ack) begin
            state_d  = S_IDLE;
            req_d    = 1'b0;
            wbv_d    = 1'b1;
            wbrd_d   = rd_q;
            wbdata_d = q_store ? 32'd0 : load_val;
            wbrw_d   = q_store ? 1'b0 : rw_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      off_q    <= 2'd0;
      op_q     <= 4'd0;
      rd_q     <= 5'd0;
      rw_q     <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      wstrb_q  <= 4'd0;
      wbv_q    <= 1'b0;
      wbrd_q   <= 5'd0;
      wbdata_q <= 32'd0;
      wbrw_q   <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      off_q    <= off_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rw_q     <= rw_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      wbv_q    <= wbv_d;
      wbrd_q   <= wbrd_d;
      wbdata_q <= wbdata_d;
      wbrw_q   <= wbrw_d;
      mis_q    <= mis_d;
    end
  end

  assign mem_stall    = (state_q == S_REQ);
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_wstrb   = wstrb_q;
  assign wb_valid     = wbv_q;
  assign wb_rd        = wbrd_q;
  assign wb_data      = wbdata_q;
  assign wb_reg_write = wbrw_q;
  assign misalign_exc = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: passthrough, loads, stores,
// misalignment, halt freeze and reset abandonment.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [3:0]  ex_mem_op;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_reg_write;
  logic        misalign_exc;

  int n_chk = 0;
  int n_pass = 0;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_mem_op(ex_mem_op),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_reg_write(wb_reg_write), .misalign_exc(misalign_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [4:0] rd,
                       input logic rw);
    ex_valid      = 1'b1;
    ex_mem_op     = op;
    ex_alu_result = alu;
    ex_store_data = sd;
    ex_rd         = rd;
    ex_reg_write  = rw;
  endtask

  task automatic idle_in();
    ex_valid = 1'b0;
    ex_mem_op = 4'd0;
  endtask

  task automatic chk_reset_outs(input string p);
    chk({p, "_req"}, {31'd0, dmem_req}, 32'd0);
    chk({p, "_we"}, {31'd0, dmem_we}, 32'd0);
    chk({p, "_addr"}, dmem_addr, 32'd0);
    chk({p, "_wdata"}, dmem_wdata, 32'd0);
    chk({p, "_wstrb"}, {28'd0, dmem_wstrb}, 32'd0);
    chk({p, "_stall"}, {31'd0, mem_stall}, 32'd0);
    chk({p, "_wbv"}, {31'd0, wb_valid}, 32'd0);
    chk({p, "_wbrd"}, {27'd0, wb_rd}, 32'd0);
    chk({p, "_wbdata"}, wb_data, 32'd0);
    chk({p, "_wbrw"}, {31'd0, wb_reg_write}, 32'd0);
    chk({p, "_mis"}, {31'd0, misalign_exc}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    halt = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    ex_alu_result = 32'd0;
    ex_store_data = 32'd0;
    ex_rd = 5'd0;
    ex_reg_write = 1'b0;
    idle_in();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk_reset_outs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // passthrough accepted on first edge after release
    issue(4'b0000, 32'h0000_1234, 32'd0, 5'd5, 1'b1);
    step();
    idle_in();
    chk("pt_wbv", {31'd0, wb_valid}, 32'd1);
    chk("pt_data", wb_data, 32'h0000_1234);
    chk("pt_rd", {27'd0, wb_rd}, 32'd5);
    chk("pt_rw", {31'd0, wb_reg_write}, 32'd1);
    chk("pt_req", {31'd0, dmem_req}, 32'd0);
    step();
    chk("pt_pulse", {31'd0, wb_valid}, 32'd0);

    // LB with ack in the third stall cycle
    issue(4'b0001, 32'h0000_0103, 32'd0, 5'd7, 1'b1);
    step();
    idle_in();
    chk("lb_req", {31'd0, dmem_req}, 32'd1);
    chk("lb_addr", dmem_addr, 32'h0000_0100);
    chk("lb_we", {31'd0, dmem_we}, 32'd0);
    chk("lb_stall1", {31'd0, mem_stall}, 32'd1);
    step();
    chk("lb_stall2", {31'd0, mem_stall}, 32'd1);
    step();
    chk("lb_stall3", {31'd0, mem_stall}, 32'd1);
    chk("lb_addr_hold", dmem_addr, 32'h0000_0100);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h80FF_FF7F;
    step();
    dmem_ack = 1'b0;
    chk("lb_stall_off", {31'd0, mem_stall}, 32'd0);
    chk("lb_req_off", {31'd0, dmem_req}, 32'd0);
    chk("lb_wbv", {31'd0, wb_valid}, 32'd1);
    chk("lb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_rd", {27'd0, wb_rd}, 32'd7);
    chk("lb_rw", {31'd0, wb_reg_write}, 32'd1);

    // SH upper half
    issue(4'b1010, 32'h0000_0202, 32'hAAAA_BEEF, 5'd3, 1'b1);
    step();
    idle_in();
    chk("sh_we", {31'd0, dmem_we}, 32'd1);
    chk("sh_addr", dmem_addr, 32'h0000_0200);
    chk("sh_wstrb", {28'd0, dmem_wstrb}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("sh_wbv", {31'd0, wb_valid}, 32'd1);
    chk("sh_rw", {31'd0, wb_reg_write}, 32'd0);
    chk("sh_data", wb_data, 32'd0);

    // misaligned LW, then an op on the next cycle
    issue(4'b0011, 32'h0000_0301, 32'd0, 5'd4, 1'b1);
    step();
    chk("mis_exc", {31'd0, misalign_exc}, 32'd1);
    chk("mis_wbv", {31'd0, wb_valid}, 32'd0);
    chk("mis_req", {31'd0, dmem_req}, 32'd0);
    chk("mis_stall", {31'd0, mem_stall}, 32'd0);
    issue(4'b0000, 32'h0000_ABCD, 32'd0, 5'd9, 1'b0);
    step();
    chk("mis_pulse", {31'd0, misalign_exc}, 32'd0);
    chk("next_wbv", {31'd0, wb_valid}, 32'd1);
    chk("next_data", wb_data, 32'h0000_ABCD);
    chk("next_rw", {31'd0, wb_reg_write}, 32'd0);

    // reserved op: passthrough without writeback
    issue(4'b0111, 32'h0000_0055, 32'd0, 5'd2, 1'b1);
    step();
    chk("rsv_wbv", {31'd0, wb_valid}, 32'd1);
    chk("rsv_rw", {31'd0, wb_reg_write}, 32'd0);
    chk("rsv_data", wb_data, 32'h0000_0055);
    chk("rsv_req", {31'd0, dmem_req}, 32'd0);

    // no instruction, stray ack in IDLE
    idle_in();
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("nov_wbv", {31'd0, wb_valid}, 32'd0);
    chk("nov_req", {31'd0, dmem_req}, 32'd0);
    chk("nov_stall", {31'd0, mem_stall}, 32'd0);

    // LHU held by halt while ack is pending
    issue(4'b0101, 32'h0000_0400, 32'd0, 5'd11, 1'b1);
    step();
    idle_in();
    chk("lhu_req", {31'd0, dmem_req}, 32'd1);
    halt = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'h0000_8001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("halt%0d_req", i), {31'd0, dmem_req}, 32'd1);
      chk($sformatf("halt%0d_stall", i), {31'd0, mem_stall}, 32'd1);
      chk($sformatf("halt%0d_wbv", i), {31'd0, wb_valid}, 32'd0);
      chk($sformatf("halt%0d_addr", i), dmem_addr, 32'h0000_0400);
    end
    halt = 1'b0;
    step();
    dmem_ack = 1'b0;
    chk("lhu_wbv", {31'd0, wb_valid}, 32'd1);
    chk("lhu_data", wb_data, 32'h0000_8001);
    chk("lhu_rd", {27'd0, wb_rd}, 32'd11);
    step();
    chk("lhu_pulse", {31'd0, wb_valid}, 32'd0);

    // SB, then reset in REQ
    issue(4'b1001, 32'h0000_0501, 32'h1234_5678, 5'd6, 1'b1);
    step();
    idle_in();
    chk("sb_wstrb", {28'd0, dmem_wstrb}, 32'h2);
    chk("sb_wdata", dmem_wdata, 32'h7878_7878);
    chk("sb_addr", dmem_addr, 32'h0000_0500);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outs("arst");
    @(negedge clk);
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("arst_nowb1", {31'd0, wb_valid}, 32'd0);
    chk("arst_noreq", {31'd0, dmem_req}, 32'd0);
    step();
    chk("arst_nowb2", {31'd0, wb_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
